// File: rtl/vector_sequencer.sv
// rtl/vector_sequencer.sv - RESET/NMI/BRK/IRQ entry sequencer for the 6502 core
// Pushes PC and P, fetches the selected vector and hands PC, S and the I flag back to the core.
module vector_sequencer #(
  parameter int          ADDR_W       = 16,
  parameter int          NUM_IRQ      = 1,
  parameter logic [7:0]  STACK_PAGE   = 8'h01,
  parameter logic [15:0] RESET_VEC    = 16'hFFFC,
  parameter logic [15:0] NMI_VEC      = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC      = 16'hFFFE,
  parameter logic [15:0] IRQ_EXT_BASE = 16'hFFE0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               boundary,
  input  logic               brk_req,
  input  logic               nmi,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               i_flag,
  input  logic [15:0]        pc_in,
  input  logic [7:0]         p_in,
  input  logic [7:0]         s_in,
  input  logic [7:0]         rd_data,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [7:0]         wr_data,
  output logic               wr_en,
  output logic               int_pending,
  output logic               busy,
  output logic [15:0]        pc_out,
  output logic               pc_load,
  output logic [7:0]         s_out,
  output logic               set_i,
  output logic [NUM_IRQ-1:0] irq_ack
);

  typedef enum logic [3:0] {
    IDLE, RST_1, RST_2, RST_3, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H, LOAD
  } state_t;
  typedef enum logic [1:0] {K_NMI, K_BRK, K_IRQ} kind_t;

  state_t      state;
  kind_t       kind;
  logic [2:0]  chan;
  logic [2:0]  irq_sel;
  logic [7:0]  s_reg;
  logic [7:0]  p_reg;
  logic [7:0]  pc_lo;
  logic [7:0]  vec_lo;
  logic        nmi_q;
  logic        nmi_pending;
  logic        nmi_rise;
  logic        ack_en;
  logic        is_brk;
  logic [15:0] irq_vec;

  // Lowest-index request wins, so scan downwards and let the last hit stand.
  always_comb begin
    irq_sel = 3'd0;
    for (int n = NUM_IRQ - 1; n >= 0; n--) begin
      if (irq[n]) irq_sel = 3'(n);
    end
  end

  assign nmi_rise    = nmi & ~nmi_q;
  assign int_pending = nmi_pending | brk_req | ((|irq) & ~i_flag);
  assign is_brk      = brk_req & ~nmi_pending;
  assign irq_vec     = (chan == 3'd0) ? IRQ_VEC
                                      : IRQ_EXT_BASE + {12'd0, chan - 3'd1, 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RST_1;
      mem_addr    <= '0;
      wr_data     <= '0;
      wr_en       <= 1'b0;
      busy        <= 1'b1;
      pc_out      <= '0;
      pc_load     <= 1'b0;
      s_out       <= '0;
      set_i       <= 1'b0;
      irq_ack     <= '0;
      nmi_pending <= 1'b0;
      nmi_q       <= 1'b0;
      kind        <= K_IRQ;
      chan        <= '0;
      s_reg       <= '0;
      p_reg       <= '0;
      pc_lo       <= '0;
      vec_lo      <= '0;
      ack_en      <= 1'b0;
    end else begin
      nmi_q   <= nmi;
      pc_load <= 1'b0;
      set_i   <= 1'b0;
      irq_ack <= '0;
      wr_en   <= 1'b0;
      if (nmi_rise) nmi_pending <= 1'b1;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (boundary && int_pending) begin
            state    <= PUSH_H;
            busy     <= 1'b1;
            pc_lo    <= pc_in[7:0];
            p_reg    <= (p_in | 8'h30) & {3'b111, is_brk, 4'hF};
            s_reg    <= s_in - 8'd1;
            mem_addr <= ADDR_W'({STACK_PAGE, s_in});
            wr_data  <= pc_in[15:8];
            wr_en    <= 1'b1;
            chan     <= irq_sel;
            if (nmi_pending)  kind <= K_NMI;
            else if (brk_req) kind <= K_BRK;
            else              kind <= K_IRQ;
          end
        end
        // Dummy stack cycles: address the stack, never write.
        RST_1: begin
          state    <= RST_2;
          mem_addr <= ADDR_W'({STACK_PAGE, s_in});
          s_reg    <= s_in - 8'd1;
        end
        RST_2: begin
          state    <= RST_3;
          mem_addr <= ADDR_W'({STACK_PAGE, s_reg});
          s_reg    <= s_reg - 8'd1;
        end
        RST_3: begin
          state    <= VEC_L;
          mem_addr <= ADDR_W'(RESET_VEC);
          s_reg    <= s_reg - 8'd1;
          ack_en   <= 1'b0;
        end
        PUSH_H: begin
          state    <= PUSH_L;
          mem_addr <= ADDR_W'({STACK_PAGE, s_reg});
          wr_data  <= pc_lo;
          wr_en    <= 1'b1;
          s_reg    <= s_reg - 8'd1;
        end
        PUSH_L: begin
          state    <= PUSH_P;
          mem_addr <= ADDR_W'({STACK_PAGE, s_reg});
          wr_data  <= p_reg;
          wr_en    <= 1'b1;
          s_reg    <= s_reg - 8'd1;
        end
        // A late NMI edge hijacks BRK/IRQ here; the pushed B bit is already committed.
        PUSH_P: begin
          state <= VEC_L;
          if (kind == K_NMI || nmi_pending || nmi_rise) begin
            mem_addr    <= ADDR_W'(NMI_VEC);
            nmi_pending <= 1'b0;
            ack_en      <= 1'b0;
          end else if (kind == K_BRK) begin
            mem_addr <= ADDR_W'(IRQ_VEC);
            ack_en   <= 1'b0;
          end else begin
            mem_addr <= ADDR_W'(irq_vec);
            ack_en   <= 1'b1;
          end
        end
        VEC_L: begin
          state    <= VEC_H;
          mem_addr <= mem_addr + ADDR_W'(1);
          vec_lo   <= rd_data;
        end
        VEC_H: begin
          state   <= LOAD;
          pc_out  <= {rd_data, vec_lo};
          s_out   <= s_reg;
          pc_load <= 1'b1;
          set_i   <= 1'b1;
          irq_ack <= ack_en ? (NUM_IRQ'(1) << chan) : '0;
        end
        LOAD: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// tb/tb_vector_sequencer.sv - randomized self-checking bench for vector_sequencer
module tb_vector_sequencer;
  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          boundary = 1'b0, brk_req = 1'b0, nmi = 1'b0, i_flag = 1'b0;
  logic [NI-1:0] irq = '0;
  logic [15:0]   pc_in = '0;
  logic [7:0]    p_in = '0, s_in = '0;
  logic [7:0]    rd_data;
  logic [15:0]   mem_addr;
  logic [7:0]    wr_data;
  logic          wr_en, int_pending, busy, pc_load, set_i;
  logic [15:0]   pc_out;
  logic [7:0]    s_out;
  logic [NI-1:0] irq_ack;

  logic [7:0]    mem [0:65535];
  logic [15:0]   wa[$];
  logic [7:0]    wd[$];
  int            vectors = 0;
  int            miscompares = 0;

  vector_sequencer #(.ADDR_W(16), .NUM_IRQ(NI)) dut (
    .clk(clk), .reset(reset), .boundary(boundary), .brk_req(brk_req), .nmi(nmi),
    .irq(irq), .i_flag(i_flag), .pc_in(pc_in), .p_in(p_in), .s_in(s_in),
    .rd_data(rd_data), .mem_addr(mem_addr), .wr_data(wr_data), .wr_en(wr_en),
    .int_pending(int_pending), .busy(busy), .pc_out(pc_out), .pc_load(pc_load),
    .s_out(s_out), .set_i(set_i), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;
  assign rd_data = mem[mem_addr];

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(wr_data);
    end
  end

  // Reference model: vector map and stack image derived from the architectural rules.
  function automatic logic [15:0] ref_vec_addr(input bit is_nmi, input bit is_brk, input int ch);
    if (is_nmi) return 16'hFFFA;
    if (is_brk || ch == 0) return 16'hFFFE;
    return 16'hFFE0 + 16'(2 * (ch - 1));
  endfunction

  function automatic logic [15:0] ref_pc(input logic [15:0] va);
    return {mem[va + 16'd1], mem[va]};
  endfunction

  function automatic int ref_chan(input logic [NI-1:0] r);
    for (int n = 0; n < NI; n++) if (r[n]) return n;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_vectors();
    for (int a = 16'hFFE0; a <= 16'hFFFF; a++) mem[a] = 8'($urandom);
  endtask

  // Pulses boundary and waits (bounded) for pc_load; cyc counts edges from boundary.
  task automatic run_seq(input bit drop_irq, input bit poke, input int nmi_at, output int cyc);
    wa.delete();
    wd.delete();
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    brk_req  = 1'b0;
    cyc      = 1;
    if (drop_irq) irq = '0;
    while (pc_load !== 1'b1 && cyc < 40) begin
      if (cyc == nmi_at) nmi = 1'b1;
      boundary = poke && (cyc == 2);
      tick();
      cyc++;
    end
    boundary = 1'b0;
    while (wa.size() < 3) begin
      wa.push_back('x);
      wd.push_back('x);
    end
  endtask

  task automatic test_reset();
    int cyc;
    fill_vectors();
    mem[16'hFFFC] = 8'h34;
    mem[16'hFFFD] = 8'h12;
    s_in  = 8'hFD;
    reset = 1'b1;
    repeat (2) tick();
    vectors++;
    if ({mem_addr, wr_data, wr_en, pc_out, pc_load, s_out, set_i, irq_ack} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0",
               {mem_addr, wr_data, wr_en, pc_out, pc_load, s_out, set_i, irq_ack});
    end
    vectors++;
    if (busy !== 1'b1 || int_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: busy=%b int_pending=%b expected 1/0", busy, int_pending);
    end
    wa.delete();
    wd.delete();
    reset = 1'b0;
    cyc = 0;
    while (pc_load !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    vectors++;
    if (cyc !== 5) begin miscompares++; $display("FAIL reset_latency: got %0d expected 5", cyc); end
    vectors++;
    if (pc_out !== 16'h1234) begin miscompares++; $display("FAIL reset_pc: got %h expected 1234", pc_out); end
    vectors++;
    if (s_out !== 8'hFA) begin miscompares++; $display("FAIL reset_s: got %h expected fa", s_out); end
    vectors++;
    if (wa.size() !== 0 || set_i !== 1'b1 || irq_ack !== '0) begin
      miscompares++;
      $display("FAIL reset_side: writes=%0d set_i=%b ack=%b expected 0/1/0", wa.size(), set_i, irq_ack);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || pc_load !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b pc_load=%b expected 0/0", busy, pc_load);
    end
  endtask

  task automatic test_irq_basic();
    int cyc;
    fill_vectors();
    irq = 4'b0001; i_flag = 1'b0; pc_in = 16'hC005; p_in = 8'h20; s_in = 8'hFF;
    #1;
    vectors++;
    if (int_pending !== 1'b1) begin miscompares++; $display("FAIL irq_pending: got %b expected 1", int_pending); end
    run_seq(1'b0, 1'b0, -1, cyc);
    vectors++;
    if (cyc !== 6) begin miscompares++; $display("FAIL irq_latency: got %0d expected 6", cyc); end
    vectors++;
    if ({wa[0], wa[1], wa[2]} !== {16'h01FF, 16'h01FE, 16'h01FD} || {wd[0], wd[1], wd[2]} !== 24'hC00520) begin
      miscompares++;
      $display("FAIL irq_pushes: got %h/%h expected 01ff01fe01fd/c00520", {wa[0], wa[1], wa[2]}, {wd[0], wd[1], wd[2]});
    end
    vectors++;
    if (wa.size() !== 3) begin miscompares++; $display("FAIL irq_write_count: got %0d expected 3", wa.size()); end
    vectors++;
    if (pc_out !== ref_pc(16'hFFFE)) begin
      miscompares++; $display("FAIL irq_pc: got %h expected %h", pc_out, ref_pc(16'hFFFE));
    end
    vectors++;
    if ({s_out, set_i, irq_ack, busy} !== {8'hFC, 1'b1, 4'b0001, 1'b1}) begin
      miscompares++;
      $display("FAIL irq_load: s=%h set_i=%b ack=%b busy=%b expected fc/1/0001/1", s_out, set_i, irq_ack, busy);
    end
    irq = '0;
    tick();
  endtask

  task automatic test_brk_wrap();
    int cyc;
    logic [7:0] ep;
    fill_vectors();
    brk_req = 1'b1; irq = '0; s_in = 8'h01; pc_in = 16'($urandom); p_in = 8'($urandom);
    ep = p_in; ep[5] = 1'b1; ep[4] = 1'b1;
    run_seq(1'b0, 1'b0, -1, cyc);
    vectors++;
    if ({wa[0], wa[1], wa[2]} !== {16'h0101, 16'h0100, 16'h01FF}) begin
      miscompares++; $display("FAIL brk_wrap_addr: got %h expected 0101010001ff", {wa[0], wa[1], wa[2]});
    end
    vectors++;
    if ({wd[0], wd[1], wd[2]} !== {pc_in, ep}) begin
      miscompares++; $display("FAIL brk_push_data: got %h expected %h", {wd[0], wd[1], wd[2]}, {pc_in, ep});
    end
    vectors++;
    if ({pc_out, s_out, irq_ack} !== {ref_pc(16'hFFFE), 8'hFE, 4'b0000}) begin
      miscompares++;
      $display("FAIL brk_load: got %h expected %h", {pc_out, s_out, irq_ack}, {ref_pc(16'hFFFE), 8'hFE, 4'b0000});
    end
    tick();
  endtask

  task automatic test_irq_priority();
    int cyc;
    logic [7:0] ep;
    fill_vectors();
    irq = 4'b1100; i_flag = 1'b0; pc_in = 16'($urandom); p_in = 8'($urandom); s_in = 8'($urandom);
    ep = p_in; ep[5] = 1'b1; ep[4] = 1'b0;
    run_seq(1'b0, 1'b0, -1, cyc);
    vectors++;
    if ({pc_out, irq_ack} !== {ref_pc(16'hFFE2), 4'b0100}) begin
      miscompares++;
      $display("FAIL prio_channel: got %h expected %h", {pc_out, irq_ack}, {ref_pc(16'hFFE2), 4'b0100});
    end
    vectors++;
    if (wd[2] !== ep) begin miscompares++; $display("FAIL prio_p_push: got %h expected %h", wd[2], ep); end
    tick();
    tick();
    i_flag = 1'b1;
    #1;
    vectors++;
    if (int_pending !== 1'b0) begin miscompares++; $display("FAIL masked_pending: got %b expected 0", int_pending); end
    wa.delete();
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    repeat (3) tick();
    vectors++;
    if (busy !== 1'b0 || wa.size() !== 0) begin
      miscompares++; $display("FAIL masked_idle: busy=%b writes=%0d expected 0/0", busy, wa.size());
    end
    irq = '0; i_flag = 1'b0;
  endtask

  task automatic test_nmi_hijack();
    int cyc;
    logic [7:0] s0, ep;
    fill_vectors();
    irq = 4'b0001; i_flag = 1'b0; pc_in = 16'($urandom); p_in = 8'($urandom); s_in = 8'($urandom);
    s0 = s_in; ep = p_in; ep[5] = 1'b1; ep[4] = 1'b0;
    run_seq(1'b0, 1'b0, 2, cyc);
    vectors++;
    if ({pc_out, irq_ack} !== {ref_pc(16'hFFFA), 4'b0000}) begin
      miscompares++;
      $display("FAIL hijack_vector: got %h expected %h", {pc_out, irq_ack}, {ref_pc(16'hFFFA), 4'b0000});
    end
    vectors++;
    if ({wd[2], s_out} !== {ep, s0 - 8'd3}) begin
      miscompares++; $display("FAIL hijack_stack: got %h expected %h", {wd[2], s_out}, {ep, s0 - 8'd3});
    end
    irq = '0;
    tick();
    tick();
    vectors++;
    if (int_pending !== 1'b0) begin miscompares++; $display("FAIL hijack_cleared: got %b expected 0", int_pending); end
    wa.delete();
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    repeat (3) tick();
    vectors++;
    if (busy !== 1'b0 || wa.size() !== 0) begin
      miscompares++; $display("FAIL nmi_level_retrigger: busy=%b writes=%0d expected 0/0", busy, wa.size());
    end
    nmi = 1'b0;
    tick();
    nmi = 1'b1;
    tick();
    vectors++;
    if (int_pending !== 1'b1) begin miscompares++; $display("FAIL nmi_edge_pending: got %b expected 1", int_pending); end
    brk_req = 1'b1; pc_in = 16'($urandom); p_in = 8'($urandom); s_in = 8'($urandom);
    ep = p_in; ep[5] = 1'b1; ep[4] = 1'b0;
    run_seq(1'b0, 1'b0, -1, cyc);
    vectors++;
    if ({cyc[7:0], pc_out, wd[2], irq_ack} !== {8'd6, ref_pc(16'hFFFA), ep, 4'b0000}) begin
      miscompares++;
      $display("FAIL nmi_over_brk: got %h expected %h", {cyc[7:0], pc_out, wd[2], irq_ack},
               {8'd6, ref_pc(16'hFFFA), ep, 4'b0000});
    end
    nmi = 1'b0;
    tick();
    vectors++;
    if (int_pending !== 1'b0) begin miscompares++; $display("FAIL nmi_consumed: got %b expected 0", int_pending); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic [NI-1:0] r, ea;
      logic [7:0]    s0, ep;
      logic [15:0]   va;
      bit            nm, bk, fl, go, as_brk, serviced;
      int            ch, cyc;
      fill_vectors();
      r  = NI'($urandom);
      nm = ($urandom_range(0, 3) == 0);
      bk = ($urandom_range(0, 2) == 0);
      fl = 1'($urandom);
      pc_in = 16'($urandom); p_in = 8'($urandom); s_in = 8'($urandom);
      if (nm) begin
        nmi = 1'b1; tick(); nmi = 1'b0; tick();
      end
      irq = r; brk_req = bk; i_flag = fl;
      ch       = ref_chan(r);
      go       = nm || bk || (ch >= 0 && !fl);
      as_brk   = !nm && bk;
      serviced = go && !nm && !bk;
      s0 = s_in; ep = p_in; ep[5] = 1'b1; ep[4] = as_brk;
      ea = '0;
      if (serviced) ea[ch] = 1'b1;
      #1;
      vectors++;
      if (int_pending !== go) begin
        miscompares++; $display("FAIL rand_pending[%0d]: got %b expected %b", it, int_pending, go);
      end
      if (go) begin
        run_seq(1'($urandom), 1'($urandom), -1, cyc);
        va = ref_vec_addr(nm, as_brk, ch);
        vectors++;
        if ({wa[0], wa[1], wa[2]} !== {8'h01, s0, 8'h01, s0 - 8'd1, 8'h01, s0 - 8'd2} ||
            {wd[0], wd[1], wd[2]} !== {pc_in, ep} || wa.size() !== 3) begin
          miscompares++;
          $display("FAIL rand_pushes[%0d]: got %h/%h n=%0d expected %h/%h", it, {wa[0], wa[1], wa[2]},
                   {wd[0], wd[1], wd[2]}, wa.size(), {8'h01, s0, 8'h01, s0 - 8'd1, 8'h01, s0 - 8'd2}, {pc_in, ep});
        end
        vectors++;
        if ({cyc[7:0], pc_out, s_out, set_i, irq_ack} !== {8'd6, ref_pc(va), s0 - 8'd3, 1'b1, ea}) begin
          miscompares++;
          $display("FAIL rand_load[%0d]: got %h expected %h (vec %h)", it, {cyc[7:0], pc_out, s_out, set_i, irq_ack},
                   {8'd6, ref_pc(va), s0 - 8'd3, 1'b1, ea}, va);
        end
      end else begin
        wa.delete();
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        repeat (3) tick();
        vectors++;
        if (busy !== 1'b0 || wa.size() !== 0) begin
          miscompares++; $display("FAIL rand_no_start[%0d]: busy=%b writes=%0d expected 0/0", it, busy, wa.size());
        end
      end
      irq = '0; brk_req = 1'b0; i_flag = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [7:0] s0;
    irq = 4'b0010; i_flag = 1'b0; s_in = 8'($urandom);
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    tick();
    tick();
    vectors++;
    if (wr_en !== 1'b1) begin miscompares++; $display("FAIL mid_push_p_write: got %b expected 1", wr_en); end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({wr_en, busy, mem_addr, pc_load} !== {1'b0, 1'b1, 16'h0000, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_async_reset: wr_en=%b busy=%b addr=%h pc_load=%b expected 0/1/0000/0", wr_en, busy, mem_addr, pc_load);
    end
    fill_vectors();
    irq = '0;
    s_in = 8'($urandom);
    s0 = s_in;
    tick();
    wa.delete();
    wd.delete();
    reset = 1'b0;
    cyc = 0;
    while (pc_load !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    vectors++;
    if ({cyc[7:0], pc_out, s_out, 8'(wa.size())} !== {8'd5, ref_pc(16'hFFFC), s0 - 8'd3, 8'd0}) begin
      miscompares++;
      $display("FAIL mid_restart: got %h expected %h", {cyc[7:0], pc_out, s_out, 8'(wa.size())},
               {8'd5, ref_pc(16'hFFFC), s0 - 8'd3, 8'd0});
    end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    test_reset();
    test_irq_basic();
    test_brk_wrap();
    test_irq_priority();
    test_nmi_hijack();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
Parametrised interrupt and reset entry engine for the 6502 core. It runs the RESET, NMI, BRK and multi-channel IRQ entry sequences: stack pushes of PC and P, vector fetch, and PC/S/I-flag hand-back. The core hands control to it at the instruction boundary (FETCH). It generalises the core's fixed two-cycle reset-vector fetch to a configurable address width, stack page, vector map and IRQ channel count, and adds NMI edge detection and NMI hijack.

Parameters:
ADDR_W, 16, memory address width (>=16; vectors zero-extended)
NUM_IRQ, 1, IRQ channels (1..8); channel 0 has highest priority
STACK_PAGE, 8'h01, upper address byte for stack accesses
RESET_VEC, 16'hFFFC, reset vector low-byte address
NMI_VEC, 16'hFFFA, NMI vector low-byte address
IRQ_VEC, 16'hFFFE, IRQ channel 0 and BRK vector
IRQ_EXT_BASE, 16'hFFE0, channel n>=1 vector at IRQ_EXT_BASE + 2*(n-1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
boundary  in  1  one-cycle pulse from the core in FETCH
brk_req  in  1  qualifies boundary: current opcode is BRK
nmi  in  1  non-maskable request, rising-edge sensitive
irq  in  NUM_IRQ  level requests
i_flag  in  1  core P[I]; masks irq only
pc_in  in  16  return PC to push
p_in  in  8  status to push
s_in  in  8  current stack pointer
rd_data  in  8  memory read data, valid the cycle after mem_addr
mem_addr  out  ADDR_W  memory address (registered)
wr_data  out  8  write data (registered)
wr_en  out  1  write strobe (registered)
int_pending  out  1  combinational: a sequence will start if boundary is asserted now
busy  out  1  sequence in progress
pc_out  out  16  new PC
pc_load  out  1  one-cycle load pulse for pc_out, s_out and set_i
s_out  out  8  new stack pointer
set_i  out  1  core sets P[I] on pc_load
irq_ack  out  NUM_IRQ  one-hot, pulses with pc_load for the serviced channel

Behaviour:
- Reset values: mem_addr=0, wr_data=0, wr_en=0, busy=1, pc_out=0, pc_load=0, s_out=0, set_i=0, irq_ack=0, nmi_pending=0, state=RST_1.
- States: IDLE, RST_1, RST_2, RST_3, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H, LOAD. Every state lasts one cycle. Outputs listed for a state are registered on the edge entering that state.
- The reset sequence starts on the first clk after reset deasserts: RST_1, RST_2, RST_3, VEC_L. The RST states are dummy stack cycles with wr_en=0; the internal S copy decrements in each (s_in-3 on exit).
- Priority at boundary: NMI pending > BRK (brk_req) > lowest-index irq[n] with i_flag=0. If nothing qualifies, stay IDLE.
- int_pending = nmi_pending | brk_req | (|irq & ~i_flag).
- On entry the block latches pc_in, p_in and s_in.
- PUSH_H: mem_addr={STACK_PAGE,S}, wr_data=PC[15:8], wr_en=1, S-=1.
- PUSH_L: same addressing, PC[7:0].
- PUSH_P: same addressing, P with bit5=1 and bit4=1 only for BRK.
- The vector is selected on the PUSH_P->VEC_L edge.
- VEC_L: mem_addr=vec, wr_en=0. VEC_H: mem_addr=vec+1, low byte captured from rd_data. LOAD: high byte captured; pc_out, s_out, pc_load=1, set_i=1, irq_ack; then IDLE.
- busy=1 from the state after boundary through LOAD inclusive. Latency from boundary to pc_load is 6 cycles for interrupts and 5 cycles after reset release.
- Stack pointer arithmetic is 8-bit modulo: S=8'h00 decrements to 8'hFF. mem_addr stays in STACK_PAGE.
- NMI edge detection: a registered nmi rising edge sets nmi_pending. nmi_pending clears on the edge entering VEC_L of an NMI-vectored sequence. A level held high does not retrigger.
- NMI hijack: if nmi_pending sets during PUSH_H, PUSH_L or PUSH_P of a BRK or IRQ sequence, the NMI vector is used and nmi_pending is cleared. The pushed B bit keeps its original value. No irq_ack is issued.
- An edge arriving in VEC_L or later stays pending for the next boundary.
- boundary while busy is ignored. irq deasserting after sequence start does not abort the sequence.
- reset asserted mid-sequence: all outputs go to their reset values asynchronously (wr_en drops immediately). The reset sequence then restarts.

Test Plan:
- Reset release with mem[FFFC]=34 and mem[FFFD]=12, s_in=FD → pc_load 5 cycles later, pc_out=1234, s_out=FA, no wr_en.
- irq[0]=1, i_flag=0, pc_in=C005, p_in=20, s_in=FF, boundary → writes 01FF=C0, 01FE=05, 01FD=20; vector FFFE/FFFF fetched; s_out=FC, set_i=1, irq_ack=1.
- BRK with s_in=01 → writes at 0101, 0100, 01FF (wrap); pushed P has bit4=1; s_out=FE.
- NUM_IRQ=4: irq=1100 with i_flag=0 → channel 2 serviced, vector FFE2, irq_ack=0100. With i_flag=1 → int_pending=0, block stays IDLE.
- nmi rises during PUSH_L of an IRQ sequence → vector FFFA, no irq_ack, nmi_pending cleared. nmi held high afterwards → no second NMI.
- reset asserted in PUSH_P → wr_en=0 in the same cycle. After release a full reset sequence runs and pc_out equals the reset vector contents.
